// File: rtl/echo_feedback_mixer.sv
// Echo feedback/mix engine: forms buffer write-back and audible output
// from dry + gain*delayed, and glides the buffer delay toward a target.
//
// Ports:
//   clk, reset_n               clock, async active-low reset
//   dry_valid, dry_sample      dry input strobe and sample
//   dly_valid, dly_sample      delayed sample from the buffer (level valid)
//   fb_gain, mix_gain          unsigned Q0.GAIN_WIDTH gains
//   target_delay               requested delay length in samples
//   delay_samples              current (gliding) delay length to buffer
//   wr_valid, wr_sample        write-back strobe and sample
//   out_valid, out_sample      audible output strobe and sample
module echo_feedback_mixer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int GAIN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dry_valid,
    input  logic [DATA_WIDTH-1:0] dry_sample,
    input  logic                  dly_valid,
    input  logic [DATA_WIDTH-1:0] dly_sample,
    input  logic [GAIN_WIDTH-1:0] fb_gain,
    input  logic [GAIN_WIDTH-1:0] mix_gain,
    input  logic [ADDR_WIDTH-1:0] target_delay,
    output logic [ADDR_WIDTH-1:0] delay_samples,
    output logic                  wr_valid,
    output logic [DATA_WIDTH-1:0] wr_sample,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_sample
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int SW = DATA_WIDTH + 1;
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Stage 1 capture
    logic                         v1;
    logic signed [DATA_WIDTH-1:0] dry1;
    logic signed [DATA_WIDTH-1:0] d1;
    logic        [GAIN_WIDTH-1:0] fb1;
    logic        [GAIN_WIDTH-1:0] mix1;

    // Stage 2 scaled products
    logic                         v2;
    logic signed [DATA_WIDTH-1:0] dry2;
    logic signed [SW-1:0]         pfb2;
    logic signed [SW-1:0]         pmix2;

    // Stage 3 wide sums
    logic                         v3;
    logic signed [SW-1:0]         wr3;
    logic signed [SW-1:0]         out3;

    logic                         v4;

    logic signed [PW-1:0]         d_ext;
    logic signed [PW-1:0]         fb_ext;
    logic signed [PW-1:0]         mix_ext;
    logic signed [PW-1:0]         pfb_full;
    logic signed [PW-1:0]         pmix_full;
    logic                         unused_lsbs;

    logic [ADDR_WIDTH-1:0]        eff_target;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] x);
        if (x[SW-1] != x[SW-2]) begin
            sat = x[SW-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sat = x[DATA_WIDTH-1:0];
        end
    endfunction

    // Gains are zero-extended so they multiply as non-negative signed values.
    always_comb begin
        d_ext     = PW'(d1);
        fb_ext    = PW'({1'b0, fb1});
        mix_ext   = PW'({1'b0, mix1});
        pfb_full  = d_ext * fb_ext;
        pmix_full = d_ext * mix_ext;
    end

    // Dropping the low GAIN_WIDTH bits is the arithmetic shift (floor).
    assign unused_lsbs = ^{pfb_full[GAIN_WIDTH-1:0], pmix_full[GAIN_WIDTH-1:0]};

    // A zero target is treated as one sample; target is never below 1,
    // so stepping toward it can never wrap.
    assign eff_target = (target_delay == '0) ? ADDR_WIDTH'(1) : target_delay;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            dry1 <= '0;
            d1   <= '0;
            fb1  <= '0;
            mix1 <= '0;
        end else begin
            v1 <= dry_valid;
            if (dry_valid) begin
                dry1 <= dry_sample;
                d1   <= dly_valid ? dly_sample : '0;
                fb1  <= fb_gain;
                mix1 <= mix_gain;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2    <= 1'b0;
            dry2  <= '0;
            pfb2  <= '0;
            pmix2 <= '0;
            v3    <= 1'b0;
            wr3   <= '0;
            out3  <= '0;
        end else begin
            v2    <= v1;
            dry2  <= dry1;
            pfb2  <= pfb_full[PW-1:GAIN_WIDTH];
            pmix2 <= pmix_full[PW-1:GAIN_WIDTH];
            v3    <= v2;
            wr3   <= SW'(dry2) + pfb2;
            out3  <= SW'(dry2) + pmix2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v4         <= 1'b0;
            wr_sample  <= '0;
            out_sample <= '0;
        end else begin
            v4 <= v3;
            if (v3) begin
                wr_sample  <= sat(wr3);
                out_sample <= sat(out3);
            end
        end
    end

    assign wr_valid  = v4;
    assign out_valid = v4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_samples <= ADDR_WIDTH'(1);
        end else if (dry_valid) begin
            if (delay_samples < eff_target) begin
                delay_samples <= delay_samples + ADDR_WIDTH'(1);
            end else if (delay_samples > eff_target) begin
                delay_samples <= delay_samples - ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_echo_feedback_mixer.sv
// Bench for echo_feedback_mixer: vector table, reset/glide sequences
// and randomized traffic against an arithmetic reference model.
module tb_echo_feedback_mixer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dry_valid = 1'b0;
    logic [31:0] dry_sample = '0;
    logic        dly_valid = 1'b0;
    logic [31:0] dly_sample = '0;
    logic [15:0] fb_gain = '0;
    logic [15:0] mix_gain = '0;
    logic [15:0] target_delay = 16'd1;
    logic [15:0] delay_samples;
    logic        wr_valid;
    logic [31:0] wr_sample;
    logic        out_valid;
    logic [31:0] out_sample;

    echo_feedback_mixer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dry_valid    (dry_valid),
        .dry_sample   (dry_sample),
        .dly_valid    (dly_valid),
        .dly_sample   (dly_sample),
        .fb_gain      (fb_gain),
        .mix_gain     (mix_gain),
        .target_delay (target_delay),
        .delay_samples(delay_samples),
        .wr_valid     (wr_valid),
        .wr_sample    (wr_sample),
        .out_valid    (out_valid),
        .out_sample   (out_sample)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mdelay = 1;

    typedef struct {
        int          due;
        logic [31:0] wr;
        logic [31:0] out;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int   t;

    typedef struct {
        logic [31:0] dry;
        logic [31:0] dly;
        logic        dv;
        logic [15:0] fb;
        logic [15:0] mix;
        logic [31:0] exp_wr;
        logic [31:0] exp_out;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d",
                     name, act, req, cyc);
        end
    endtask

    // dry + floor(d*g/2^16), clamped to the 32-bit signed range
    function automatic logic [31:0] ref_mix(input int dry, input int d,
                                            input int g);
        longint p;
        longint s;
        p = (longint'(d) * longint'(g)) >>> 16;
        s = longint'(dry) + p;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s[31:0];
    endfunction

    always @(negedge reset_n) begin
        q.delete();
        mdelay = 1;
    end

    always @(posedge clk) begin
        cyc++;
        if (reset_n && dry_valid) begin
            t = (target_delay == 0) ? 1 : int'(target_delay);
            if (mdelay < t) mdelay++;
            else if (mdelay > t) mdelay--;
            e.due = cyc + 3;
            e.wr  = ref_mix(int'(dry_sample),
                            dly_valid ? int'(dly_sample) : 0, int'(fb_gain));
            e.out = ref_mix(int'(dry_sample),
                            dly_valid ? int'(dly_sample) : 0, int'(mix_gain));
            q.push_back(e);
        end
        #1;
        chk("delay", 32'(delay_samples), 32'(mdelay));
        chk("valid_pair", 32'(wr_valid), 32'(out_valid));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("strobe", 32'(out_valid), 32'd1);
            chk("model_wr", wr_sample, q[0].wr);
            chk("model_out", out_sample, q[0].out);
            void'(q.pop_front());
        end else begin
            chk("no_strobe", 32'(out_valid), 32'd0);
        end
    end

    task automatic drive(input logic [31:0] dry, input logic [31:0] dly,
                         input logic dv, input logic [15:0] fb,
                         input logic [15:0] mix);
        @(negedge clk);
        dry_sample = dry;
        dly_sample = dly;
        dly_valid  = dv;
        fb_gain    = fb;
        mix_gain   = mix;
        dry_valid  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dry_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        dry_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{32'h00001000, 32'h00012345, 1'b0, 16'h8000, 16'h4000,
                    32'h00001000, 32'h00001000};
        vecs[1] = '{32'h00000000, 32'h00010000, 1'b1, 16'h8000, 16'h4000,
                    32'h00008000, 32'h00004000};
        vecs[2] = '{32'h00000000, 32'hFFFFFFFD, 1'b1, 16'h8000, 16'h4000,
                    32'hFFFFFFFE, 32'hFFFFFFFF};
        vecs[3] = '{32'h7FFFFFF0, 32'h7FFFFFFF, 1'b1, 16'hFFFF, 16'hFFFF,
                    32'h7FFFFFFF, 32'h7FFFFFFF};
        vecs[4] = '{32'h80000010, 32'h80000000, 1'b1, 16'hFFFF, 16'hFFFF,
                    32'h80000000, 32'h80000000};
        vecs[5] = '{32'd100, 32'd1000, 1'b1, 16'h0000, 16'hFFFF,
                    32'd100, 32'd1099};

        repeat (3) @(negedge clk);
        chk("reset_delay", 32'(delay_samples), 32'd1);
        chk("reset_wr", wr_sample, 32'd0);
        chk("reset_out", out_sample, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Table: each vector appears exactly three edges after capture.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].dry, vecs[i].dly, vecs[i].dv,
                  vecs[i].fb, vecs[i].mix);
            @(negedge clk);
            dry_valid = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_wr", wr_sample, vecs[i].exp_wr);
            chk("tbl_out", out_sample, vecs[i].exp_out);
            idle(1);
        end

        // Reset with three samples in flight.
        target_delay = 16'd9;
        for (int i = 0; i < 3; i++)
            drive(32'h11110000 + 32'(i), 32'd5, 1'b1, 16'h1234, 16'h4321);
        @(negedge clk);
        dry_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_wr", wr_sample, 32'd0);
        chk("rst_out", out_sample, 32'd0);
        chk("rst_delay", 32'(delay_samples), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(6);
        drive(32'h00000042, 32'd0, 1'b0, 16'h0, 16'h0);
        idle(6);

        // Glide up to 5, then down to the floor of 1.
        do_reset();
        target_delay = 16'd5;
        for (int i = 0; i < 5; i++) begin
            drive(32'(i), 32'd0, 1'b0, 16'h0, 16'h0);
            @(posedge clk);
            #2;
            chk("glide_up", 32'(delay_samples), 32'((i < 4) ? i + 2 : 5));
        end
        target_delay = 16'd0;
        for (int i = 0; i < 5; i++) begin
            drive(32'(i), 32'd0, 1'b0, 16'h0, 16'h0);
            @(posedge clk);
            #2;
            chk("glide_dn", 32'(delay_samples), 32'((i < 4) ? 4 - i : 1));
        end
        idle(5);

        // Back-to-back random traffic.
        target_delay = 16'($urandom_range(0, 20));
        for (int i = 0; i < 16; i++)
            drive($urandom, $urandom, 1'($urandom), 16'($urandom),
                  16'($urandom));
        idle(1);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) target_delay = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 3) != 0)
                drive($urandom, $urandom_range(0, 1) != 0 ?
                      $urandom : $urandom_range(0, 255),
                      1'($urandom), 16'($urandom), 16'($urandom));
            else
                idle(1);
        end
        idle(1);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        chk("drain2", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
